// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared definitions for the memory-access / write-back stage.
//   - register-file bus widths, zero word and write-enable levels
//   - memory-operation encodings carried on ex_memop
//   - stage state encodings
//   - small helpers that classify a memory operation
package mem_wb_stage_pkg;

  localparam int                  REG_BUS_W     = 32;
  localparam int                  REG_ADDR_W    = 5;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD    = '0;
  localparam logic                WRITE_ENABLE  = 1'b1;
  localparam logic                WRITE_DISABLE = 1'b0;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Encodings outside LB..SW are treated as plain ALU results.
  function automatic logic is_mem(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lo[0];
      MEM_LW, MEM_SW:          return (lo != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus interfaces used by mem_wb_stage.
//   ex_if   : execute-stage handshake (valid/ready) plus the retiring
//             instruction's payload. master = execute stage, slave = this stage.
//   dmem_if : data-memory req/ack port. master = this stage, slave = memory.
interface ex_if #(
  parameter int ADDR_W = 32
);
  import mem_wb_stage_pkg::*;

  logic                  ex_valid;
  logic                  ex_ready;
  logic                  ex_wreg;
  logic [REG_ADDR_W-1:0] ex_waddr;
  logic [REG_BUS_W-1:0]  ex_wdata;
  logic [3:0]            ex_memop;
  logic [ADDR_W-1:0]     ex_maddr;
  logic [31:0]           ex_mstore;

  modport master (
    output ex_valid, ex_wreg, ex_waddr, ex_wdata, ex_memop, ex_maddr, ex_mstore,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_wreg, ex_waddr, ex_wdata, ex_memop, ex_maddr, ex_mstore,
    output ex_ready
  );
endinterface

interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_wb_stage_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane steering for the data-memory port.
//   st_op/st_lo/st_data -> st_be/st_wdata : byte enables and lane-replicated
//                                            store data for the op being accepted
//   ld_op/ld_lo/ld_word -> ld_data        : lane selection and sign/zero
//                                            extension of a returned read word
module mem_lane_fmt
  import mem_wb_stage_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replicating the data across every lane lets the memory pick it up
  // purely from the byte enables.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_op)
      MEM_SB: begin
        st_be    = 4'b0001 << st_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_word[{ld_lo, 3'b000} +: 8];
    half_sel = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data  = ld_word;
    case (ld_op)
      MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ld_data = {24'h000000, byte_sel};
      MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ld_data = {16'h0000, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage feeding the register file.
//   clk, rst        : clock, asynchronous active-high reset
//   ex   (slave)    : one retiring instruction per valid/ready handshake
//   dmem (master)   : req/ack data-memory port, request held until ack
//   wb_we/waddr/wdata : registered one-cycle register-file write pulse
//   exc_misalign    : one-cycle pulse when a misaligned access is dropped
//   exc_bus_timeout : one-cycle pulse when ACK_TIMEOUT busy cycles pass without ack
// ACK_TIMEOUT = 0 disables the timeout.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_if.slave                   ex,
  dmem_if.master                dmem,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic [REG_BUS_W-1:0]  wb_wdata,
  output logic                  exc_misalign,
  output logic                  exc_bus_timeout
);

  localparam int               CNT_W      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic             TIMEOUT_EN = (ACK_TIMEOUT != 0);
  // Last busy-cycle count before giving up: the edge that would make the
  // count equal ACK_TIMEOUT is the abort edge.
  localparam logic [CNT_W-1:0] CNT_LAST   = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wreg_q, wreg_d;
  logic [1:0]            lo_q, lo_d;

  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  wb_we_d;
  logic [REG_ADDR_W-1:0] wb_waddr_d;
  logic [REG_BUS_W-1:0]  wb_wdata_d;
  logic                  mis_d, tmo_d;

  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [31:0]           ld_data;

  mem_lane_fmt u_lane_fmt (
    .st_op    (ex.ex_memop),
    .st_lo    (ex.ex_maddr[1:0]),
    .st_data  (ex.ex_mstore),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_op    (op_q),
    .ld_lo    (lo_q),
    .ld_word  (dmem.dmem_rdata),
    .ld_data  (ld_data)
  );

  // Gated by rst so the upstream stage never sees a transfer while in reset.
  assign ex.ex_ready       = (state_q == ST_IDLE) && !rst;

  assign dmem.dmem_req     = req_q;
  assign dmem.dmem_we      = we_q;
  assign dmem.dmem_addr    = addr_q;
  assign dmem.dmem_be      = be_q;
  assign dmem.dmem_wdata   = wdata_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wreg_d     = wreg_q;
    lo_d       = lo_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_we_d    = WRITE_DISABLE;
    wb_waddr_d = wb_waddr;
    wb_wdata_d = wb_wdata;
    mis_d      = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ex.ex_valid) begin
          if (!is_mem(ex.ex_memop)) begin
            wb_we_d    = ex.ex_wreg && (ex.ex_waddr != '0);
            wb_waddr_d = ex.ex_waddr;
            wb_wdata_d = ex.ex_wdata;
          end else if (is_misaligned(ex.ex_memop, ex.ex_maddr[1:0])) begin
            mis_d = 1'b1;
          end else begin
            op_d    = ex.ex_memop;
            rd_d    = ex.ex_waddr;
            wreg_d  = ex.ex_wreg;
            lo_d    = ex.ex_maddr[1:0];
            req_d   = 1'b1;
            we_d    = is_store(ex.ex_memop);
            addr_d  = {ex.ex_maddr[ADDR_W-1:2], 2'b00};
            be_d    = st_be;
            wdata_d = st_wdata;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        // Ack is tested first so it wins when it lands on the abort edge.
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (is_load(op_q)) begin
            wb_we_d    = wreg_q && (rd_q != '0);
            wb_waddr_d = rd_q;
            wb_wdata_d = ld_data;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      op_q            <= MEM_NONE;
      rd_q            <= '0;
      wreg_q          <= 1'b0;
      lo_q            <= 2'b00;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      be_q            <= 4'b0000;
      wdata_q         <= ZERO_WORD;
      wb_we           <= WRITE_DISABLE;
      wb_waddr        <= '0;
      wb_wdata        <= ZERO_WORD;
      exc_misalign    <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_q            <= op_d;
      rd_q            <= rd_d;
      wreg_q          <= wreg_d;
      lo_q            <= lo_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      be_q            <= be_d;
      wdata_q         <= wdata_d;
      wb_we           <= wb_we_d;
      wb_waddr        <= wb_waddr_d;
      wb_wdata        <= wb_wdata_d;
      exc_misalign    <= mis_d;
      exc_bus_timeout <= tmo_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases with literal
// expectations, then randomized traffic and random memory acks compared every
// cycle against a transaction-level model of the stage.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TMO    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_if   #(.ADDR_W(ADDR_W)) exb ();
  dmem_if #(.ADDR_W(ADDR_W)) dmb ();

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        exc_misalign;
  logic        exc_bus_timeout;

  mem_wb_stage #(.ACK_TIMEOUT(TMO), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex              (exb),
    .dmem            (dmb),
    .wb_we           (wb_we),
    .wb_waddr        (wb_waddr),
    .wb_wdata        (wb_wdata),
    .exc_misalign    (exc_misalign),
    .exc_bus_timeout (exc_bus_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic [3:0]  m_op   = '0;
  logic [4:0]  m_rd   = '0;
  logic        m_wreg = 1'b0;
  logic [1:0]  m_lo   = '0;

  logic        e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;
  logic        e_wb_we = 1'b0;
  logic [4:0]  e_wb_waddr = '0;
  logic [31:0] e_wb_wdata = '0;
  logic        e_mis = 1'b0, e_to = 1'b0;

  function automatic int op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [1:0] lo,
                                           input logic [31:0] word);
    longint      v;
    logic [31:0] sh;
    bit          sgn;
    sh  = word >> (8 * lo);
    sgn = (op == MEM_LB) || (op == MEM_LH);
    case (op_size(op))
      1: begin v = longint'(sh & 32'hFF);   if (sgn && v >= 128)   v -= 256;   end
      2: begin v = longint'(sh & 32'hFFFF); if (sgn && v >= 32768) v -= 65536; end
      default: v = longint'(word);
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_wait = 0;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    e_wb_we = 1'b0; e_wb_waddr = '0; e_wb_wdata = '0; e_mis = 1'b0; e_to = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0]  op;
    logic [31:0] a, d;
    int          sz;
    e_wb_we = 1'b0; e_mis = 1'b0; e_to = 1'b0;
    if (!m_busy) begin
      if (exb.ex_valid) begin
        op = exb.ex_memop; a = exb.ex_maddr; d = exb.ex_mstore;
        sz = op_size(op);
        if (sz == 0) begin
          e_wb_we    = exb.ex_wreg && (exb.ex_waddr != 0);
          e_wb_waddr = exb.ex_waddr;
          e_wb_wdata = exb.ex_wdata;
        end else if ((a % sz) != 0) begin
          e_mis = 1'b1;
        end else begin
          m_busy = 1'b1; m_wait = 0;
          m_op = op; m_rd = exb.ex_waddr; m_wreg = exb.ex_wreg; m_lo = a[1:0];
          e_req  = 1'b1;
          e_we   = (op >= MEM_SB);
          e_addr = a - (a % 4);
          if (!e_we || sz == 4) e_be = 4'hF;
          else if (sz == 1)     e_be = 4'b0001 << m_lo;
          else                  e_be = 4'b0011 << m_lo;
          if (sz == 1)      e_wdata = (d & 32'hFF) * 32'h01010101;
          else if (sz == 2) e_wdata = (d & 32'hFFFF) * 32'h00010001;
          else              e_wdata = d;
        end
      end
    end else if (dmb.dmem_ack) begin
      m_busy = 1'b0; e_req = 1'b0;
      if (m_op < MEM_SB && m_wreg && m_rd != 0) begin
        e_wb_we    = 1'b1;
        e_wb_waddr = m_rd;
        e_wb_wdata = load_val(m_op, m_lo, dmb.dmem_rdata);
      end
    end else begin
      m_wait++;
      if (TMO != 0 && m_wait == TMO) begin
        m_busy = 1'b0; e_req = 1'b0; e_to = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("cmp ex_ready", 32'(exb.ex_ready), 32'(!m_busy && !rst));
        check("cmp dmem_req", 32'(dmb.dmem_req), 32'(e_req));
        if (e_req) begin
          check("cmp dmem_we",   32'(dmb.dmem_we), 32'(e_we));
          check("cmp dmem_addr", dmb.dmem_addr,    e_addr);
          check("cmp dmem_be",   32'(dmb.dmem_be), 32'(e_be));
          if (e_we) check("cmp dmem_wdata", dmb.dmem_wdata, e_wdata);
        end
        check("cmp wb_we", 32'(wb_we), 32'(e_wb_we));
        if (e_wb_we) begin
          check("cmp wb_waddr", 32'(wb_waddr), 32'(e_wb_waddr));
          check("cmp wb_wdata", wb_wdata, e_wb_wdata);
        end
        check("cmp exc_misalign",    32'(exc_misalign),    32'(e_mis));
        check("cmp exc_bus_timeout", 32'(exc_bus_timeout), 32'(e_to));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                       input logic wreg, input logic [31:0] wdata, input logic [31:0] mstore);
    exb.ex_valid  = 1'b1;
    exb.ex_memop  = op;
    exb.ex_maddr  = addr;
    exb.ex_waddr  = rd;
    exb.ex_wreg   = wreg;
    exb.ex_wdata  = wdata;
    exb.ex_mstore = mstore;
  endtask

  task automatic load_case(input logic [3:0] op, input logic [31:0] exp_data, input string tag);
    issue(op, 32'h103, 5'd7, 1'b1, 32'h0, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check({tag, " dmem_req"},  32'(dmb.dmem_req), 32'd1);
    check({tag, " dmem_addr"}, dmb.dmem_addr, 32'h100);
    check({tag, " dmem_be"},   32'(dmb.dmem_be), 32'hF);
    check({tag, " ex_ready busy"}, 32'(exb.ex_ready), 32'd0);
    cyc();
    dmb.dmem_ack   = 1'b1;
    dmb.dmem_rdata = 32'h80FF_1234;
    check({tag, " ex_ready ack cycle"}, 32'(exb.ex_ready), 32'd0);
    cyc();
    dmb.dmem_ack = 1'b0;
    check({tag, " req dropped"}, 32'(dmb.dmem_req), 32'd0);
    check({tag, " wb_we"},    32'(wb_we), 32'd1);
    check({tag, " wb_waddr"}, 32'(wb_waddr), 32'd7);
    check({tag, " wb_wdata"}, wb_wdata, exp_data);
    check({tag, " ex_ready after"}, 32'(exb.ex_ready), 32'd1);
    cyc();
    check({tag, " wb_we pulse"}, 32'(wb_we), 32'd0);
  endtask

  initial begin
    exb.ex_valid = 1'b0; exb.ex_wreg = 1'b0; exb.ex_waddr = '0; exb.ex_wdata = '0;
    exb.ex_memop = '0;   exb.ex_maddr = '0;  exb.ex_mstore = '0;
    dmb.dmem_ack = 1'b0; dmb.dmem_rdata = '0;

    #3;
    check("rst ex_ready",   32'(exb.ex_ready), 32'd0);
    check("rst dmem_req",   32'(dmb.dmem_req), 32'd0);
    check("rst dmem_be",    32'(dmb.dmem_be), 32'd0);
    check("rst dmem_addr",  dmb.dmem_addr, 32'd0);
    check("rst wb_we",      32'(wb_we), 32'd0);
    check("rst wb_waddr",   32'(wb_waddr), 32'd0);
    check("rst wb_wdata",   wb_wdata, 32'd0);
    check("rst exc",        32'({exc_misalign, exc_bus_timeout}), 32'd0);
    cyc(); cyc();
    rst = 1'b0;

    // ALU write and its one-cycle pulse
    issue(MEM_NONE, 32'h0, 5'd3, 1'b1, 32'h0000_0005, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check("alu wb_we",    32'(wb_we), 32'd1);
    check("alu wb_waddr", 32'(wb_waddr), 32'd3);
    check("alu wb_wdata", wb_wdata, 32'd5);
    cyc();
    check("alu wb_we pulse", 32'(wb_we), 32'd0);

    // Write to x0 is suppressed
    issue(MEM_NONE, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check("x0 wb_we", 32'(wb_we), 32'd0);

    load_case(MEM_LB,  32'hFFFF_FF80, "lb");
    load_case(MEM_LBU, 32'h0000_0080, "lbu");

    // SH upper half
    issue(MEM_SH, 32'h202, 5'd9, 1'b1, 32'h0, 32'h0000_ABCD);
    cyc();
    exb.ex_valid = 1'b0;
    check("sh dmem_we",    32'(dmb.dmem_we), 32'd1);
    check("sh dmem_addr",  dmb.dmem_addr, 32'h200);
    check("sh dmem_be",    32'(dmb.dmem_be), 32'hC);
    check("sh dmem_wdata", dmb.dmem_wdata, 32'hABCD_ABCD);
    dmb.dmem_ack = 1'b1;
    cyc();
    dmb.dmem_ack = 1'b0;
    check("sh no wb_we", 32'(wb_we), 32'd0);
    check("sh req done", 32'(dmb.dmem_req), 32'd0);

    // Misaligned word load
    issue(MEM_LW, 32'h101, 5'd4, 1'b1, 32'h0, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check("mis dmem_req", 32'(dmb.dmem_req), 32'd0);
    check("mis exc",      32'(exc_misalign), 32'd1);
    check("mis ex_ready", 32'(exb.ex_ready), 32'd1);
    cyc();
    check("mis exc pulse", 32'(exc_misalign), 32'd0);

    // Ack while idle is ignored
    dmb.dmem_ack = 1'b1;
    cyc();
    dmb.dmem_ack = 1'b0;
    check("idle ack wb_we", 32'(wb_we), 32'd0);
    check("idle ack req",   32'(dmb.dmem_req), 32'd0);

    // Timeout after TMO busy cycles
    issue(MEM_LW, 32'h300, 5'd5, 1'b1, 32'h0, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check("tmo req start", 32'(dmb.dmem_req), 32'd1);
    for (int k = 1; k < TMO; k++) begin
      cyc();
      check("tmo req held", 32'(dmb.dmem_req), 32'd1);
    end
    cyc();
    check("tmo req drop", 32'(dmb.dmem_req), 32'd0);
    check("tmo exc",      32'(exc_bus_timeout), 32'd1);
    check("tmo no wb",    32'(wb_we), 32'd0);
    cyc();
    check("tmo exc pulse", 32'(exc_bus_timeout), 32'd0);

    // Reset while busy drops the request immediately
    issue(MEM_LW, 32'h400, 5'd6, 1'b1, 32'h0, 32'h0);
    cyc();
    exb.ex_valid = 1'b0;
    check("rstbusy req", 32'(dmb.dmem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstbusy req drop", 32'(dmb.dmem_req), 32'd0);
    check("rstbusy ready",    32'(exb.ex_ready), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("rstbusy no wb", 32'(wb_we), 32'd0);

    // Randomized traffic with random acks
    for (int i = 0; i < 3000; i++) begin
      exb.ex_valid   = ($urandom_range(0, 9) < 6);
      exb.ex_memop   = 4'($urandom_range(0, 8));
      exb.ex_wreg    = ($urandom_range(0, 3) != 0);
      exb.ex_waddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      exb.ex_wdata   = $urandom;
      exb.ex_maddr   = $urandom;
      exb.ex_mstore  = $urandom;
      dmb.dmem_ack   = ($urandom_range(0, 9) < 3);
      dmb.dmem_rdata = $urandom;
      cyc();
    end

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back stage, directly upstream of the register file.
- Accepts one retiring instruction per handshake from the execute stage.
- Performs byte/half/word loads and stores over a req/ack data-memory port.
- Drives the register file's write port (we/waddr/wdata) as a registered, one-cycle pulse per retired write.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for dmem_ack before aborting; 0 disables the timeout
ADDR_W, 32, data-memory address width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept; transfer occurs when ex_valid & ex_ready at posedge
ex_wreg  in  1  instruction writes a register
ex_waddr  in  5  destination register
ex_wdata  in  32  ALU result (non-memory ops)
ex_memop  in  4  MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
ex_maddr  in  ADDR_W  byte address of the access
ex_mstore  in  32  store data (low bits significant)
dmem_req  out  1  request valid, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; rdata valid this cycle
dmem_rdata  in  32  read word
wb_we  out  1  register-file write enable
wb_waddr  out  5  register-file write address
wb_wdata  out  32  register-file write data
exc_misalign  out  1  one-cycle pulse: misaligned access dropped
exc_bus_timeout  out  1  one-cycle pulse: ack timeout, access dropped

Behaviour:
- Reset (async): state IDLE; timeout counter 0; all outputs 0, including wb_*, dmem_* and exc_*. ex_ready also reads 0 while rst is high.
- A reset asserted mid-transaction drops dmem_req immediately and produces no write-back.
- States: IDLE and BUSY.
- IDLE: ex_ready = 1. On accept:
  - Non-memory op: at the next edge, wb_waddr = ex_waddr, wb_wdata = ex_wdata, wb_we = ex_wreg & (ex_waddr != 0). Latency is 1 cycle. State stays IDLE, so back-to-back accepts run at full rate.
  - Misaligned memory op (LH/LHU/SH with addr[0] != 0; LW/SW with addr[1:0] != 0): no request is issued. exc_misalign = 1 for one cycle, wb_we = 0, state stays IDLE.
  - Aligned memory op: capture op, rd, wreg and addr[1:0]. At the next edge drive dmem_req = 1 plus dmem_we/addr/be/wdata, set wb_we = 0, go to BUSY.
- BUSY: ex_ready = 0. All dmem_* outputs are held stable. The counter increments each cycle without ack.
  - dmem_ack high: at the edge, dmem_req = 0 and state returns to IDLE.
  - Load: wb_we = wreg & (rd != 0), wb_wdata = formatted data.
  - Store: wb_we = 0.
  - ex_ready stays 0 during the ack cycle. The next accept is possible in the following cycle.
- Timeout: when ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT with no ack, then at that edge: dmem_req = 0, exc_bus_timeout pulses for 1 cycle, no write-back, state returns to IDLE. If ack and the limit coincide, ack wins.
- dmem_ack is ignored in IDLE.
- Store lanes:
  - SB: be = 1 << addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011 (addr[1] = 0) or 1100, wdata = half replicated x2.
  - SW: be = 1111.
  - Loads: be = 1111.
- Load format: select the lane by addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- wb_we is a single-cycle pulse; it deasserts on the next edge unless another write retires.

Decomposition:
- Shared package/defines holds:
  - memop encodings (MEM_NONE = 0, LB, LH, LW, LBU, LHU, SB, SH, SW);
  - state encodings;
  - existing RegBus/RegAddrBus widths, ZeroWord, WriteEnable levels.
- One sub-module, mem_lane_fmt (combinational): store lane/byte-enable generation and load extraction/extension.

Test Plan:
- ALU write: accept ex_waddr = 3, ex_wdata = 0x0000_0005, ex_wreg = 1 -> next cycle wb_we = 1, wb_waddr = 3, wb_wdata = 5; cycle after, wb_we = 0.
- Write to x0: ex_waddr = 0, ex_wreg = 1 -> wb_we stays 0.
- LB at 0x103, ack after 2 cycles with rdata 0x80FF_1234 -> dmem_addr = 0x100, be = 1111; ex_ready = 0 until the cycle after ack; wb_wdata = 0xFFFF_FF80 to rd. Repeat with LBU -> 0x0000_0080.
- SH at 0x202, data 0xABCD -> dmem_we = 1, addr = 0x200, be = 1100, wdata = 0xABCD_ABCD; no wb_we on ack.
- LW at 0x101 -> no dmem_req, exc_misalign pulses 1 cycle, ex_ready stays 1.
- ACK_TIMEOUT = 4, load with no ack -> dmem_req drops after 4 BUSY cycles, exc_bus_timeout pulses, no write-back. Separately, assert rst mid-BUSY -> dmem_req = 0 immediately.
